// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
// Shares one I2C master controller between N_REQ requesters. A round-robin
// arbiter picks a requester, latches its command (direction, address, byte
// count) and drives the master's enable inputs. It then follows the
// transaction to completion. An address NACK causes a retry, up to MAX_RETRY
// extra attempts. A stuck launch or a stuck transfer is aborted after
// TO_LIMIT cycles.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   req         : per-requester request level
//   req_rw      : per-requester direction (1 = read)
//   req_addr    : per-requester 7-bit slave address, requester i at [7i+6:7i]
//   req_nbyte   : per-requester byte count, requester i at [5i+4:5i]
//   gnt         : one-hot grant for the active transaction
//   done / err  : 1-cycle completion / failure pulse for the granted requester
//   m_ena       : enable to the master (high while launching)
//   m_rw, m_addr, m_nbyte : latched command for the master
//   m_abort     : 1-cycle pulse forcing the master back to idle
//   m_busy      : master is not idle
//   m_nack      : 1-cycle pulse, address ACK slot sampled high
//   m_done      : 1-cycle pulse, STOP condition finished
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2,
  parameter int TO_W      = 16,
  parameter int TO_LIMIT  = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [5*N_REQ-1:0] req_nbyte,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               m_ena,
  output logic               m_rw,
  output logic [6:0]         m_addr,
  output logic [4:0]         m_nbyte,
  output logic               m_abort,
  input  logic               m_busy,
  input  logic               m_nack,
  input  logic               m_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   win_q;
  logic [RW-1:0]   retry_cnt_q;
  logic            nack_flag_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            busy_q;

  logic            win_found_d;
  logic [IW-1:0]   win_idx_d;

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found_d && req[(int'(last_q) + k) % N_REQ]) begin
        win_found_d = 1'b1;
        win_idx_d   = IW'((int'(last_q) + k) % N_REQ);
      end
    end
  end

  wire busy_rise = m_busy && !busy_q;
  wire to_expire = (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(N_REQ - 1);
      win_q       <= '0;
      retry_cnt_q <= '0;
      nack_flag_q <= 1'b0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      m_ena       <= 1'b0;
      m_rw        <= 1'b0;
      m_addr      <= '0;
      m_nbyte     <= '0;
      m_abort     <= 1'b0;
    end else begin
      busy_q  <= m_busy;
      done    <= '0;
      err     <= '0;
      m_abort <= 1'b0;

      // Saturating attempt timer; entry into LAUNCH/RUN below overrides it.
      if ((state_q == S_LAUNCH || state_q == S_RUN) && to_cnt_q != '1) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (|req) state_q <= S_ARB;
        end

        S_ARB: begin
          // The request may have been withdrawn during the arbitration cycle.
          if (win_found_d) begin
            win_q       <= win_idx_d;
            gnt         <= N_REQ'(1) << win_idx_d;
            m_rw        <= req_rw[win_idx_d];
            m_addr      <= req_addr[win_idx_d*7 +: 7];
            m_nbyte     <= req_nbyte[win_idx_d*5 +: 5];
            retry_cnt_q <= '0;
            nack_flag_q <= 1'b0;
            to_cnt_q    <= '0;
            m_ena       <= 1'b1;
            state_q     <= S_LAUNCH;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_LAUNCH: begin
          // A master already busy on entry does not count; wait for a new rise.
          if (busy_rise) begin
            m_ena       <= 1'b0;
            to_cnt_q    <= '0;
            nack_flag_q <= 1'b0;
            state_q     <= S_RUN;
          end else if (to_expire) begin
            m_ena       <= 1'b0;
            m_abort     <= 1'b1;
            err[win_q]  <= 1'b1;
            gnt         <= '0;
            state_q     <= S_RELEASE;
          end
        end

        S_RUN: begin
          // m_done takes precedence over timeout; a NACK in the same cycle
          // as m_done still counts as a NACK.
          if (m_done) begin
            if (nack_flag_q || m_nack) begin
              if (retry_cnt_q < RW'(MAX_RETRY)) begin
                retry_cnt_q <= retry_cnt_q + 1'b1;
                nack_flag_q <= 1'b0;
                to_cnt_q    <= '0;
                m_ena       <= 1'b1;
                state_q     <= S_LAUNCH;
              end else begin
                err[win_q] <= 1'b1;
                gnt        <= '0;
                state_q    <= S_RELEASE;
              end
            end else begin
              done[win_q] <= 1'b1;
              gnt         <= '0;
              state_q     <= S_RELEASE;
            end
          end else begin
            if (m_nack) nack_flag_q <= 1'b1;
            if (to_expire) begin
              m_abort    <= 1'b1;
              err[win_q] <= 1'b1;
              gnt        <= '0;
              state_q    <= S_RELEASE;
            end
          end
        end

        S_RELEASE: begin
          last_q  <= win_q;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
